// File: rtl/crtc_pkg.sv
// rtl/crtc_pkg.sv - shared CRTC constants and sync-width decode
package crtc_pkg;

  // Refresh memory address width.
  localparam int MA_W = 14;

  // Register file indices of the timing registers used by the CRTC stages.
  localparam int R0_HTOTAL     = 0;
  localparam int R1_HDISPLAYED = 1;
  localparam int R2_HSYNC_POS  = 2;
  localparam int R3_SYNC_WIDTH = 3;
  localparam int R12_START_HI  = 12;
  localparam int R13_START_LO  = 13;

  // Horizontal sync width nibble: zero encodes a 16-character pulse.
  function automatic logic [4:0] sync_width_decode(input logic [3:0] raw);
    return (raw == 4'd0) ? 5'd16 : {1'b0, raw};
  endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// rtl/crtc_sync_pulse.sv - loadable down-counter producing a fixed-width busy pulse
module crtc_sync_pulse #(
  parameter int WW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [WW-1:0] width,
  output logic          busy
);

  logic [WW-1:0] remain;

  // Busy for exactly 'width' cycles after a load; loads while busy are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      remain <= '0;
    end else if (busy) begin
      if (remain == WW'(1)) begin
        busy <= 1'b0;
      end
      remain <= remain - WW'(1);
    end else if (load) begin
      busy   <= 1'b1;
      remain <= width;
    end
  end

endmodule

// File: rtl/crtc_htiming.sv
// rtl/crtc_htiming.sv - horizontal display enable, hsync and refresh address stage
module crtc_htiming
  import crtc_pkg::*;
#(
  parameter int CW  = 8,
  parameter int MAW = MA_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [CW-1:0]  h_count,
  input  logic           h_carry,
  input  logic [CW-1:0]  r1_displayed,
  input  logic [CW-1:0]  r2_sync_pos,
  input  logic [3:0]     r3_sync_width,
  input  logic [MAW-1:0] start_addr,
  input  logic           row_end,
  input  logic           frame_start,
  output logic           hdisp,
  output logic           hsync,
  output logic [MAW-1:0] ma,
  output logic           line_start
);

  logic [CW-1:0]  next_count;
  logic           sync_load;
  logic [4:0]     sync_width;
  logic           row_latch;
  logic [MAW-1:0] ma_inc;
  logic [MAW-1:0] row_base;
  logic [MAW-1:0] row_base_upd;

  // Predict the upstream counter so every registered output lines up with it.
  always_comb begin
    next_count   = h_carry ? '0 : h_count + CW'(1);
    ma_inc       = ma + MAW'(1);
    sync_load    = (next_count == r2_sync_pos);
    sync_width   = sync_width_decode(r3_sync_width);
    // With zero displayed characters the row base keeps its value.
    row_latch    = row_end && (r1_displayed != '0) && (next_count == r1_displayed);
    row_base_upd = row_latch ? ma_inc : row_base;
  end

  crtc_sync_pulse #(
    .WW(5)
  ) u_hsync (
    .clock (clock),
    .reset (reset),
    .load  (sync_load),
    .width (sync_width),
    .busy  (hsync)
  );

  // Display enable and line-start strobe for the upcoming character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdisp      <= 1'b0;
      line_start <= 1'b0;
    end else begin
      hdisp      <= (next_count < r1_displayed);
      line_start <= (next_count == '0);
    end
  end

  // Refresh address: count along the line, reload at the wrap from the row base.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ma       <= '0;
      row_base <= '0;
    end else begin
      if (h_carry && frame_start) begin
        row_base <= start_addr;
      end else begin
        row_base <= row_base_upd;
      end
      if (h_carry) begin
        ma <= frame_start ? start_addr : row_base_upd;
      end else begin
        ma <= ma_inc;
      end
    end
  end

endmodule

// File: tb/tb_crtc_htiming.sv
// tb/tb_crtc_htiming.sv - self-checking bench for crtc_htiming
module tb_crtc_htiming;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  h_count = '0;
  logic        h_carry = 1'b0;
  logic [7:0]  r1_displayed = '0;
  logic [7:0]  r2_sync_pos = '0;
  logic [3:0]  r3_sync_width = '0;
  logic [13:0] start_addr = '0;
  logic        row_end = 1'b0;
  logic        frame_start = 1'b0;
  logic        hdisp;
  logic        hsync;
  logic [13:0] ma;
  logic        line_start;

  crtc_htiming dut (
    .clock         (clock),
    .reset         (reset),
    .h_count       (h_count),
    .h_carry       (h_carry),
    .r1_displayed  (r1_displayed),
    .r2_sync_pos   (r2_sync_pos),
    .r3_sync_width (r3_sync_width),
    .start_addr    (start_addr),
    .row_end       (row_end),
    .frame_start   (frame_start),
    .hdisp         (hdisp),
    .hsync         (hsync),
    .ma            (ma),
    .line_start    (line_start)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // segment configuration
  int cfg_r0, cfg_r1, cfg_r2, cfg_r3;
  logic [7:0] cnt;

  // reference model state
  int          line_idx;
  logic [13:0] line_base;
  logic [13:0] row_base;
  int          hs_left;
  logic        prev_hs;
  bit          fresh;

  // per-line input policy
  bit          rand_lines;
  int          fs_first_only;
  int          re_line;
  logic [13:0] fixed_sa;
  logic        cur_re, cur_fs;
  logic [13:0] cur_sa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic choose_line_inputs();
    if (rand_lines) begin
      cur_re = 1'($urandom_range(0, 1));
      cur_fs = ($urandom_range(0, 3) == 0);
      cur_sa = 14'($urandom);
    end else begin
      cur_re = (line_idx == re_line);
      cur_fs = (fs_first_only != 0) && (line_idx == 0);
      cur_sa = fixed_sa;
    end
    row_end     = cur_re;
    frame_start = cur_fs;
    start_addr  = cur_sa;
  endtask

  // One character cycle: form expectations, check at the falling edge, advance.
  task automatic cycle();
    logic        e_hd, e_hs, e_ls;
    logic [13:0] e_ma;
    int          w;
    if (cnt == 0) choose_line_inputs();
    w = (cfg_r3 == 0) ? 16 : cfg_r3;
    if (fresh) begin
      e_hd = 1'b0; e_hs = 1'b0; e_ls = 1'b0;
    end else begin
      e_hd = (int'(cnt) < cfg_r1);
      e_ls = (cnt == 0);
      if (hs_left > 0) begin
        e_hs = 1'b1;
        hs_left--;
      end else if (int'(cnt) == cfg_r2 && !prev_hs) begin
        e_hs = 1'b1;
        hs_left = w - 1;
      end else begin
        e_hs = 1'b0;
      end
    end
    prev_hs = e_hs;
    e_ma = line_base + 14'(cnt);
    @(negedge clock);
    check("hdisp", 32'(hdisp), 32'(e_hd));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("line_start", 32'(line_start), 32'(e_ls));
    check("ma", 32'(ma), 32'(e_ma));
    fresh = 0;
    if (int'(cnt) == cfg_r0) begin
      if (cur_re && cfg_r1 != 0 && cfg_r1 <= cfg_r0) row_base = line_base + 14'(cfg_r1);
      if (cur_fs) begin
        row_base  = cur_sa;
        line_base = cur_sa;
      end else begin
        line_base = row_base;
      end
      line_idx++;
    end
    @(posedge clock);
    #1;
    cnt     = (int'(cnt) == cfg_r0) ? 8'd0 : cnt + 8'd1;
    h_count = cnt;
    h_carry = (int'(cnt) == cfg_r0);
  endtask

  task automatic start_segment(input int n0, input int n1, input int n2, input int n3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_hdisp", 32'(hdisp), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_ma", 32'(ma), 32'd0);
    check("rst_line_start", 32'(line_start), 32'd0);
    cfg_r0 = n0; cfg_r1 = n1; cfg_r2 = n2; cfg_r3 = n3;
    r1_displayed  = 8'(n1);
    r2_sync_pos   = 8'(n2);
    r3_sync_width = 4'(n3);
    cnt = '0; h_count = '0; h_carry = 1'b0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    line_idx = 0; line_base = '0; row_base = '0;
    hs_left = 0; prev_hs = 1'b0; fresh = 1;
  endtask

  task automatic run_lines(input int n);
    int target = line_idx + n;
    while (line_idx < target) cycle();
  endtask

  task automatic run_until(input int l, input int c);
    int budget = 5000;
    while (!(line_idx == l && int'(cnt) == c) && budget > 0) begin
      cycle();
      budget--;
    end
    check("run_until_reached", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    // R0=9 R1=6 R2=7 R3=3, start 0x0100 loaded at the first carry
    rand_lines = 0; fs_first_only = 1; re_line = -1; fixed_sa = 14'h0100;
    start_segment(9, 6, 7, 3);
    run_lines(4);
    // row_end on one line: the next line starts at 0x0106
    re_line = line_idx;
    run_lines(1);
    #1;
    check("row_next_ma", 32'(ma), 32'h0106);
    run_lines(2);

    // 16-wide hsync spanning the wrap, then reset in the middle of the pulse
    re_line = -1;
    start_segment(39, 20, 30, 0);
    run_until(1, 35);
    #1;
    check("pre_rst_ma", 32'(ma), 32'h0123);
    check("pre_rst_hsync", 32'(hsync), 32'd1);
    start_segment(39, 20, 30, 0);
    run_lines(3);

    // address wrap past 0x3FFF
    fixed_sa = 14'h3FFC;
    start_segment(9, 6, 7, 3);
    run_until(1, 4);
    #1;
    check("ma_wrap", 32'(ma), 32'h0000);
    run_lines(2);

    // boundary registers: R1=0 with row_end, R2 beyond R0, R1 beyond R0
    rand_lines = 1;
    start_segment(9, 0, 12, 5);
    run_lines(4);
    start_segment(9, 15, 3, 2);
    run_lines(4);
    start_segment(5, 2, 0, 0);
    run_lines(6);

    // randomized configurations
    for (int s = 0; s < 10; s++) begin
      int n0, n1, n2, n3;
      n0 = $urandom_range(1, 40);
      n1 = $urandom_range(0, n0 + 3);
      n2 = $urandom_range(0, n0 + 2);
      n3 = $urandom_range(0, 15);
      start_segment(n0, n1, n2, n3);
      run_lines(5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
